// File: rtl/data_bus_bridge.sv
// data_bus_bridge: CPU load/store port to valid/ready word bus.
// Ports: CPU load/store/address/store_data/load_data/stall;
//   bus_req_* request, bus_resp_* response; err_clear/bus_error.
module data_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  input  logic        bus_resp_err,
  input  logic        err_clear,
  output logic        bus_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] CNT_LAST =
    8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic req;
  logic aligned;
  logic expired;
  logic err_evt;

  assign req     = load | store;
  assign aligned = (address[1:0] == 2'b00);
  assign expired = (cnt == CNT_LAST);

  // Misaligned access, error response, or timeout.
  always_comb begin
    err_evt = 1'b0;
    unique case (1'b1)
      (state == IDLE):
        err_evt = req & ~aligned;
      (state == WAIT):
        err_evt = bus_resp_valid
                ? bus_resp_err
                : expired;
      default:
        err_evt = 1'b0;
    endcase
  end

  assign stall = ((state == IDLE) & req)
               | (state == REQ)
               | (state == WAIT);

  assign bus_req_valid = (state == REQ);
  assign bus_req_we    = we_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      load_data <= 32'd0;
      bus_error <= 1'b0;
    end else begin
      // A new error wins over a clear.
      if (err_evt)
        bus_error <= 1'b1;
      else if (err_clear)
        bus_error <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req && aligned) begin
            state   <= REQ;
            we_q    <= store & ~load;
            addr_q  <= {address[31:2], 2'b00};
            wdata_q <= store_data;
          end else if (req) begin
            state <= DONE;
            if (load)
              load_data <= 32'd0;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            state <= WAIT;
            cnt   <= 8'd0;
          end
        end
        WAIT: begin
          if (bus_resp_valid) begin
            state <= DONE;
            if (bus_resp_err)
              load_data <= 32'd0;
            else if (!we_q)
              load_data <= bus_resp_rdata;
          end else if (expired) begin
            state     <= DONE;
            load_data <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
